// File: rtl/remote_comm.sv
// Host-side UART command link: sends a 16-bit command as two 8-N-1 frames (high byte first)
// and captures single-byte responses. Define REMOTE_COMM_START_CHECK_EN to reject start-bit glitches.
module remote_comm #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        resp_rdy,
    output logic [7:0]  resp
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW} tx_state_t;
    typedef enum logic       {RX_IDLE, RX_BUSY}         rx_state_t;

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    tx_state_t        tx_state_reg, tx_state_next;
    logic [15:0]      cmd_reg;
    logic [8:0]       tx_shift_reg;
    logic [CNT_W-1:0] tx_cnt_reg;
    logic [3:0]       tx_idx_reg;
    logic             tx_reg;
    logic             cmd_sent_reg;

    logic tx_bit_end, tx_frame_end;
    logic tx_accept, tx_load_low, tx_finish, tx_shift_bit;

    assign tx_bit_end   = (tx_state_reg != TX_IDLE) && (tx_cnt_reg == '0);
    assign tx_frame_end = tx_bit_end && (tx_idx_reg == 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_reg <= TX_IDLE;
        end else begin
            tx_state_reg <= tx_state_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        case (tx_state_reg)
            TX_IDLE: if (send_cmd)     tx_state_next = TX_HIGH;
            TX_HIGH: if (tx_frame_end) tx_state_next = TX_LOW;
            TX_LOW:  if (tx_frame_end) tx_state_next = TX_IDLE;
            default:                   tx_state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_accept    = 1'b0;
        tx_load_low  = 1'b0;
        tx_finish    = 1'b0;
        tx_shift_bit = 1'b0;
        case (tx_state_reg)
            TX_IDLE: tx_accept   = send_cmd;
            TX_HIGH: tx_load_low = tx_frame_end;
            TX_LOW:  tx_finish   = tx_frame_end;
            default: ;
        endcase
        tx_shift_bit = tx_bit_end && !tx_frame_end;
    end

    // Shift register holds the remaining data bits with the stop bit above them,
    // so the low frame's start bit is driven on the same edge that ends the high stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_reg      <= '0;
            tx_shift_reg <= '1;
            tx_cnt_reg   <= '0;
            tx_idx_reg   <= '0;
            tx_reg       <= 1'b1;
            cmd_sent_reg <= 1'b0;
        end else if (tx_accept) begin
            cmd_reg      <= cmd;
            tx_shift_reg <= {1'b1, cmd[15:8]};
            tx_cnt_reg   <= FULL_LOAD;
            tx_idx_reg   <= '0;
            tx_reg       <= 1'b0;
            cmd_sent_reg <= 1'b0;
        end else if (tx_load_low) begin
            tx_shift_reg <= {1'b1, cmd_reg[7:0]};
            tx_cnt_reg   <= FULL_LOAD;
            tx_idx_reg   <= '0;
            tx_reg       <= 1'b0;
        end else if (tx_finish) begin
            tx_reg       <= 1'b1;
            cmd_sent_reg <= 1'b1;
        end else if (tx_shift_bit) begin
            tx_reg       <= tx_shift_reg[0];
            tx_shift_reg <= {1'b1, tx_shift_reg[8:1]};
            tx_cnt_reg   <= FULL_LOAD;
            tx_idx_reg   <= tx_idx_reg + 4'd1;
        end else if (tx_state_reg != TX_IDLE) begin
            tx_cnt_reg   <= tx_cnt_reg - CNT_ONE;
        end
    end

    assign TX       = tx_reg;
    assign cmd_sent = cmd_sent_reg;

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    rx_state_t        rx_state_reg, rx_state_next;
    logic             rx_s1_reg, rx_s2_reg, rx_prev_reg;
    logic [CNT_W-1:0] rx_cnt_reg;
    logic [3:0]       rx_idx_reg;
    logic [7:0]       rx_shift_reg;
    logic [7:0]       resp_reg;
    logic             resp_rdy_reg;

    logic rx_start_edge, rx_start, rx_sample, rx_last, rx_glitch;

    assign rx_start_edge = rx_prev_reg && !rx_s2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_reg   <= 1'b1;
            rx_s2_reg   <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_s1_reg   <= RX;
            rx_s2_reg   <= rx_s1_reg;
            rx_prev_reg <= rx_s2_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_reg <= RX_IDLE;
        end else begin
            rx_state_reg <= rx_state_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        case (rx_state_reg)
            RX_IDLE: if (rx_start_edge)          rx_state_next = RX_BUSY;
            RX_BUSY: if (rx_last || rx_glitch)   rx_state_next = RX_IDLE;
            default:                             rx_state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_start  = (rx_state_reg == RX_IDLE) && rx_start_edge;
        rx_sample = (rx_state_reg == RX_BUSY) && (rx_cnt_reg == '0);
        rx_last   = rx_sample && (rx_idx_reg == 4'd9);
`ifdef REMOTE_COMM_START_CHECK_EN
        // A start sample that reads high means the edge was noise; drop the frame.
        rx_glitch = rx_sample && (rx_idx_reg == 4'd0) && rx_s2_reg;
`else
        rx_glitch = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt_reg   <= '0;
            rx_idx_reg   <= '0;
            rx_shift_reg <= '0;
        end else if (rx_start) begin
            rx_cnt_reg   <= HALF_LOAD;
            rx_idx_reg   <= '0;
        end else if (rx_sample) begin
            rx_cnt_reg   <= FULL_LOAD;
            rx_idx_reg   <= rx_idx_reg + 4'd1;
            if (rx_idx_reg >= 4'd1 && rx_idx_reg <= 4'd8) begin
                rx_shift_reg <= {rx_s2_reg, rx_shift_reg[7:1]};
            end
        end else if (rx_state_reg == RX_BUSY) begin
            rx_cnt_reg   <= rx_cnt_reg - CNT_ONE;
        end
    end

    // A completing byte wins over a simultaneous clear from an accepted command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_reg     <= '0;
            resp_rdy_reg <= 1'b0;
        end else if (rx_last) begin
            resp_reg     <= rx_shift_reg;
            resp_rdy_reg <= 1'b1;
        end else if (tx_accept || rx_start) begin
            resp_rdy_reg <= 1'b0;
        end
    end

    assign resp     = resp_reg;
    assign resp_rdy = resp_rdy_reg;

endmodule

// File: tb/tb_remote_comm.sv
// Scoreboard bench for remote_comm: expected TX bytes and responses are queued by the
// stimulus and consumed by independent TX-decoder and response monitors.
module tb_remote_comm;

    localparam int D = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd = '0;
    logic        send_cmd = 1'b0;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] tx_q[$];
    logic [7:0] resp_q[$];

    always #5 clk = ~clk;

    remote_comm #(.BAUD_DIV(D)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .send_cmd(send_cmd),
        .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] c);
        @(posedge clk); #1;
        cmd = c;
        send_cmd = 1'b1;
        @(posedge clk); #1;
        send_cmd = 1'b0;
        $display("send_cmd %04h", c);
    endtask

    task automatic drive_rx(input logic [7:0] b);
        RX = 1'b0;
        repeat (D) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (D) @(posedge clk);
        end
        RX = 1'b1;
        repeat (D) @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd_sent(input int max);
        for (int k = 0; k < max; k++) begin
            if (cmd_sent) break;
            @(posedge clk); #1;
        end
        check("cmd_sent_wait", cmd_sent, 1);
    endtask

    task automatic wait_resp_rdy(input int max);
        for (int k = 0; k < max; k++) begin
            if (resp_rdy) break;
            @(posedge clk); #1;
        end
        check("resp_rdy_wait", resp_rdy, 1);
    endtask

    // TX monitor: decode frames mid-bit and compare against the expected byte queue.
    initial begin
        logic [7:0] b;
        logic [7:0] e;
        forever begin
            @(negedge TX);
            if (!rst_n) continue;
            repeat (D / 2) @(posedge clk); #1;
            check("tx_start_bit", TX, 0);
            for (int i = 0; i < 8; i++) begin
                repeat (D) @(posedge clk); #1;
                b[i] = TX;
            end
            repeat (D) @(posedge clk); #1;
            check("tx_stop_bit", TX, 1);
            if (tx_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_unexpected: got byte %02h, expected none", b);
            end else begin
                e = tx_q.pop_front();
                check("tx_byte", b, e);
                $display("tx byte %02h (expected %02h)", b, e);
            end
        end
    end

    // Response monitor: every rising resp_rdy must deliver the next queued byte.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge resp_rdy);
            #1;
            if (resp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL resp_unexpected: got %02h, expected none", resp);
            end else begin
                e = resp_q.pop_front();
                check("resp_byte", resp, e);
                $display("resp byte %02h (expected %02h)", resp, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        // Reset state
        repeat (3) @(posedge clk); #1;
        check("rst_tx", TX, 1);
        check("rst_cmd_sent", cmd_sent, 0);
        check("rst_resp_rdy", resp_rdy, 0);
        check("rst_resp", resp, 8'h00);
        rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("idle_tx", TX, 1);

        // 0x2002 with a mid-frame 0x5555 request that must be ignored
        tx_q.push_back(8'h20);
        tx_q.push_back(8'h02);
        send(16'h2002);
        check("tx_start_n1", TX, 0);
        check("cmd_sent_low_n1", cmd_sent, 0);
        for (k = 1; k <= 25 * D; k++) begin
            @(posedge clk); #1;
            if (k == 5 * D) begin
                cmd = 16'h5555;
                send_cmd = 1'b1;
            end else if (k == 5 * D + 1) begin
                send_cmd = 1'b0;
            end
            if (cmd_sent) break;
        end
        check("cmd_sent_latency", k, 20 * D);
        check("tx_idle_after", TX, 1);

        // Response byte, then a command clears resp_rdy but keeps resp
        resp_q.push_back(8'hA5);
        drive_rx(8'hA5);
        wait_resp_rdy(4 * D);
        check("resp_a5", resp, 8'hA5);
        tx_q.push_back(8'h27);
        tx_q.push_back(8'h02);
        send(16'h2702);
        check("resp_rdy_cleared", resp_rdy, 0);
        check("resp_held", resp, 8'hA5);
        check("cmd_sent_cleared", cmd_sent, 0);
        wait_cmd_sent(25 * D);

        // Full loop with the knight answering 0xA5 after each command
        tx_q.push_back(8'h20);
        tx_q.push_back(8'h00);
        send(16'h2000);
        wait_cmd_sent(25 * D);
        resp_q.push_back(8'hA5);
        drive_rx(8'hA5);
        wait_resp_rdy(4 * D);

        tx_q.push_back(8'h24);
        tx_q.push_back(8'h02);
        send(16'h2402);
        check("loop_resp_rdy_cleared", resp_rdy, 0);
        wait_cmd_sent(25 * D);
        resp_q.push_back(8'hA5);
        fork
            drive_rx(8'hA5);
            begin
                int n;
                n = 0;
                while (!resp_rdy && n < 20 * D) begin
                    @(posedge clk); #1;
                    n++;
                end
                check("rx_latency", n, 3 + D / 2 + 9 * D);
            end
        join
        check("loop_resp", resp, 8'hA5);

        // Short low glitch on RX
`ifndef REMOTE_COMM_START_CHECK_EN
        resp_q.push_back(8'hFF);
`endif
        @(posedge clk); #1;
        RX = 1'b0;
        repeat (D / 4) @(posedge clk);
        #1;
        RX = 1'b1;
        repeat (12 * D) @(posedge clk);
        #1;
`ifdef REMOTE_COMM_START_CHECK_EN
        check("glitch_resp_rdy", resp_rdy, 0);
        check("glitch_resp", resp, 8'hA5);
`else
        check("glitch_resp_rdy", resp_rdy, 1);
        check("glitch_resp", resp, 8'hFF);
`endif
        $display("glitch test done, resp %02h", resp);

        repeat (2 * D) @(posedge clk); #1;
        check("tx_queue_empty", tx_q.size(), 0);
        check("resp_queue_empty", resp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
